// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: next-PC select codes,
// address map constants and the fault-range helper.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        NPC_SEQ = 2'b00,
        NPC_BR  = 2'b01,
        NPC_J   = 2'b10,
        NPC_JR  = 2'b11
    } npc_op_e;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
    localparam int          IM_WORDS   = 4096;
    localparam logic [31:0] NOP        = 32'h0000_0000;

    // A fetch faults when the word address is misaligned or falls outside the ROM window.
    function automatic logic is_fetch_fault(input logic [31:0] pc,
                                            input logic [31:0] first,
                                            input logic [31:0] last);
        return (pc[1:0] != 2'b00) || (pc < first) || (pc > last);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of the fetch stage's ROM, hazard-unit, ID-redirect and IF/ID signals.
// The master side is the fetch stage; the slave side is its surroundings.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic        stall;
    logic        exc_req;
    npc_op_e     npc_op;
    logic        br_cond;
    logic [15:0] imm16;
    logic [25:0] instr_index;
    logic [31:0] jr_target;
    logic [31:0] instr_f;

    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc8_d;
    logic        valid_d;
    logic        fault_d;

    modport master (
        input  stall, exc_req, npc_op, br_cond, imm16, instr_index, jr_target, instr_f,
        output pc_f, instr_d, pc_d, pc8_d, valid_d, fault_d
    );

    modport slave (
        output stall, exc_req, npc_op, br_cond, imm16, instr_index, jr_target, instr_f,
        input  pc_f, instr_d, pc_d, pc8_d, valid_d, fault_d
    );

endinterface

// File: rtl/fetch_stage_npc_calc.sv
// Combinational next-PC selection. Redirect targets are formed relative to the
// instruction sitting in ID, so the delay slot already in IF is never squashed.
module npc_calc
    import fetch_stage_pkg::*;
(
    input  logic [31:0] pc_f,
    input  logic [31:0] pc_d,
    input  logic        valid_d,
    input  npc_op_e     npc_op,
    input  logic        br_cond,
    input  logic [15:0] imm16,
    input  logic [25:0] instr_index,
    input  logic [31:0] jr_target,
    output logic [31:0] npc
);

    logic [31:0] seq_pc;
    logic [31:0] pc_d4;
    logic [31:0] br_pc;
    logic [31:0] j_pc;

    assign seq_pc = pc_f + 32'd4;
    assign pc_d4  = pc_d + 32'd4;
    assign br_pc  = pc_d4 + {{14{imm16[15]}}, imm16, 2'b00};
    assign j_pc   = {pc_d4[31:28], instr_index, 2'b00};

    // A bubble in ID carries no decision, so its npc_op is ignored.
    always_comb begin
        npc = seq_pc;
        if (valid_d) begin
            case (npc_op)
                NPC_BR:  npc = br_cond ? br_pc : seq_pc;
                NPC_J:   npc = j_pc;
                NPC_JR:  npc = jr_target;
                default: npc = seq_pc;
            endcase
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, fetch-fault tagging and the IF/ID
// pipeline register feeding decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = fetch_stage_pkg::RESET_PC,
    parameter int          IM_WORDS   = fetch_stage_pkg::IM_WORDS,
    parameter logic [31:0] EXC_VECTOR = fetch_stage_pkg::EXC_VECTOR
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master fif
);
    import fetch_stage_pkg::*;

    localparam logic [31:0] PC_LAST = RESET_PC + 32'(4 * IM_WORDS) - 32'd4;

    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic        valid_d;
    logic        fault_d;
    logic [31:0] npc;
    logic        fault_f;

    npc_calc u_npc_calc (
        .pc_f        (pc_f),
        .pc_d        (pc_d),
        .valid_d     (valid_d),
        .npc_op      (fif.npc_op),
        .br_cond     (fif.br_cond),
        .imm16       (fif.imm16),
        .instr_index (fif.instr_index),
        .jr_target   (fif.jr_target),
        .npc         (npc)
    );

    assign fault_f = is_fetch_fault(pc_f, RESET_PC, PC_LAST);

    // Priority reset > exception > stall > normal advance; a stalled redirect is
    // dropped because ID re-presents it once the stall clears.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f    <= RESET_PC;
            instr_d <= NOP;
            pc_d    <= 32'd0;
            valid_d <= 1'b0;
            fault_d <= 1'b0;
        end else if (fif.exc_req) begin
            pc_f    <= EXC_VECTOR;
            instr_d <= NOP;
            pc_d    <= 32'd0;
            valid_d <= 1'b0;
            fault_d <= 1'b0;
        end else if (!fif.stall) begin
            pc_f    <= npc;
            instr_d <= fault_f ? NOP : fif.instr_f;
            pc_d    <= pc_f;
            valid_d <= 1'b1;
            fault_d <= fault_f;
        end
    end

    assign fif.pc_f    = pc_f;
    assign fif.instr_d = instr_d;
    assign fif.pc_d    = pc_d;
    assign fif.pc8_d   = pc_d + 32'd8;
    assign fif.valid_d = valid_d;
    assign fif.fault_d = fault_d;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: a linear walk through reset, sequential
// fetch, branch/jump/jr redirects, stalls, exceptions and fetch faults.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;

    fetch_stage_if fif ();

    fetch_stage #(
        .RESET_PC   (32'h0000_3000),
        .IM_WORDS   (4096),
        .EXC_VECTOR (32'h0000_4180)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .fif   (fif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in ROM: every word is a distinct, easily recomputed pattern of its address.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'hAB00_0000 ^ a;
    endfunction

    assign fif.instr_f = rom_word(fif.pc_f);

    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic check_if_id(input string tag, input logic [31:0] pc_f,
                               input logic [31:0] pc_d, input logic [31:0] instr_d,
                               input logic valid_d, input logic fault_d);
        checkOutput({tag, " pc_f"},    fif.pc_f,           pc_f);
        checkOutput({tag, " pc_d"},    fif.pc_d,           pc_d);
        checkOutput({tag, " instr_d"}, fif.instr_d,        instr_d);
        checkOutput({tag, " valid_d"}, {31'd0, fif.valid_d}, {31'd0, valid_d});
        checkOutput({tag, " fault_d"}, {31'd0, fif.fault_d}, {31'd0, fault_d});
    endtask

    initial begin
        n_assert        = 0;
        n_fail          = 0;
        reset           = 1'b1;
        fif.stall       = 1'b0;
        fif.exc_req     = 1'b0;
        fif.npc_op      = NPC_SEQ;
        fif.br_cond     = 1'b0;
        fif.imm16       = 16'h0000;
        fif.instr_index = 26'h0;
        fif.jr_target   = 32'h0;

        applyStimulus(2);
        check_if_id("reset", 32'h3000, 32'h0, 32'h0, 1'b0, 1'b0);

        reset = 1'b0;
        applyStimulus(1);
        check_if_id("seq A", 32'h3004, 32'h3000, rom_word(32'h3000), 1'b1, 1'b0);
        checkOutput("seq A pc8_d", fif.pc8_d, 32'h3008);
        applyStimulus(1);
        check_if_id("seq B", 32'h3008, 32'h3004, rom_word(32'h3004), 1'b1, 1'b0);
        applyStimulus(1);
        check_if_id("seq C", 32'h300C, 32'h3008, rom_word(32'h3008), 1'b1, 1'b0);

        applyStimulus(2);
        checkOutput("br setup pc_d", fif.pc_d, 32'h3010);
        fif.npc_op  = NPC_BR;
        fif.imm16   = 16'hFFFC;
        fif.br_cond = 1'b1;
        applyStimulus(1);
        check_if_id("br taken", 32'h3004, 32'h3014, rom_word(32'h3014), 1'b1, 1'b0);
        fif.npc_op = NPC_SEQ;
        applyStimulus(1);
        check_if_id("br target", 32'h3008, 32'h3004, rom_word(32'h3004), 1'b1, 1'b0);

        applyStimulus(3);
        checkOutput("br nt setup pc_d", fif.pc_d, 32'h3010);
        fif.npc_op  = NPC_BR;
        fif.br_cond = 1'b0;
        applyStimulus(1);
        checkOutput("br not taken pc_f", fif.pc_f, 32'h3018);
        fif.npc_op = NPC_SEQ;

        applyStimulus(3);
        checkOutput("j setup pc_d", fif.pc_d, 32'h3020);
        fif.npc_op      = NPC_J;
        fif.instr_index = 26'h0000C40;
        applyStimulus(1);
        check_if_id("j", 32'h3100, 32'h3024, rom_word(32'h3024), 1'b1, 1'b0);

        fif.npc_op    = NPC_JR;
        fif.jr_target = 32'h3002;
        applyStimulus(1);
        checkOutput("jr pc_f", fif.pc_f, 32'h3002);
        fif.npc_op = NPC_SEQ;
        applyStimulus(1);
        check_if_id("misaligned", 32'h3006, 32'h3002, NOP, 1'b1, 1'b1);

        fif.npc_op    = NPC_JR;
        fif.jr_target = 32'h3040;
        applyStimulus(1);
        checkOutput("jr from faulted pc_f", fif.pc_f, 32'h3040);
        fif.npc_op = NPC_SEQ;
        applyStimulus(1);
        check_if_id("realigned", 32'h3044, 32'h3040, rom_word(32'h3040), 1'b1, 1'b0);

        fif.stall   = 1'b1;
        fif.npc_op  = NPC_BR;
        fif.br_cond = 1'b1;
        fif.imm16   = 16'h0010;
        applyStimulus(1);
        check_if_id("stall 1", 32'h3044, 32'h3040, rom_word(32'h3040), 1'b1, 1'b0);
        applyStimulus(1);
        check_if_id("stall 2", 32'h3044, 32'h3040, rom_word(32'h3040), 1'b1, 1'b0);
        fif.stall = 1'b0;
        applyStimulus(1);
        check_if_id("stall release", 32'h3084, 32'h3044, rom_word(32'h3044), 1'b1, 1'b0);
        fif.npc_op = NPC_SEQ;

        fif.stall   = 1'b1;
        fif.exc_req = 1'b1;
        applyStimulus(1);
        check_if_id("exc", 32'h4180, 32'h0, NOP, 1'b0, 1'b0);
        fif.stall       = 1'b0;
        fif.exc_req     = 1'b0;
        fif.npc_op      = NPC_J;
        fif.instr_index = 26'h0000123;
        applyStimulus(1);
        check_if_id("bubble ignores j", 32'h4184, 32'h4180, rom_word(32'h4180), 1'b1, 1'b0);

        fif.npc_op    = NPC_JR;
        fif.jr_target = 32'h6FF8;
        applyStimulus(1);
        checkOutput("jr 6FF8 pc_f", fif.pc_f, 32'h6FF8);
        fif.npc_op = NPC_SEQ;
        applyStimulus(2);
        check_if_id("last word", 32'h7000, 32'h6FFC, rom_word(32'h6FFC), 1'b1, 1'b0);
        applyStimulus(1);
        check_if_id("run-off", 32'h7004, 32'h7000, NOP, 1'b1, 1'b1);

        reset         = 1'b1;
        fif.stall     = 1'b1;
        fif.npc_op    = NPC_JR;
        fif.jr_target = 32'h5000;
        applyStimulus(1);
        check_if_id("mid reset", 32'h3000, 32'h0, NOP, 1'b0, 1'b0);
        reset      = 1'b0;
        fif.stall  = 1'b0;
        fif.npc_op = NPC_SEQ;
        applyStimulus(1);
        check_if_id("after reset", 32'h3004, 32'h3000, rom_word(32'h3000), 1'b1, 1'b0);

        fif.npc_op    = NPC_JR;
        fif.jr_target = 32'h2FFC;
        applyStimulus(1);
        fif.npc_op = NPC_SEQ;
        applyStimulus(1);
        check_if_id("below rom", 32'h3000, 32'h2FFC, NOP, 1'b1, 1'b1);

        fif.npc_op    = NPC_JR;
        fif.jr_target = 32'hFFFF_FFFC;
        applyStimulus(1);
        fif.npc_op = NPC_SEQ;
        applyStimulus(1);
        check_if_id("wrap", 32'h0000_0000, 32'hFFFF_FFFC, NOP, 1'b1, 1'b1);
        checkOutput("wrap pc8_d", fif.pc8_d, 32'h0000_0004);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
